data_memory_responder: RTL and testbench

- Target (responder) end of the CPU data-memory interface: a handshaked, multi-cycle word memory that the load/store stage will drive once data accesses move off the zero-latency combinational path.
- Accepts one request at a time over a valid/ready request channel and performs the access after a fixed latency.
- Returns read data and an error flag over a valid/ready response channel.
- Supports byte-strobed writes and a debug snapshot of the array for the testbench.

---
 rtl/mem_bus_pkg.sv | 30 +++
 rtl/mem_resp_latency_counter.sv | 40 ++++
 rtl/data_memory_responder.sv | 183 ++++++++++++++++++
 tb/tb_data_memory_responder.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_bus_pkg.sv
// Shared types and helpers for the CPU data-memory handshake bus.
// Imported by both the responder and the CPU-side initiator.
package mem_bus_pkg;

  localparam int unsigned WORD_BYTES = 4;
  localparam int unsigned WORD_W     = 8 * WORD_BYTES;
  localparam int unsigned ADDR_W     = 32;
  localparam int unsigned CNT_W      = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } resp_state_t;

  // Replace each strobed byte of old_word with the matching byte of wdata.
  function automatic logic [WORD_W-1:0] byte_merge(
    input logic [WORD_W-1:0]     old_word,
    input logic [WORD_W-1:0]     wdata,
    input logic [WORD_BYTES-1:0] wstrb
  );
    logic [WORD_W-1:0] merged;
    merged = old_word;
    for (int i = 0; i < int'(WORD_BYTES); i++) begin
      if (wstrb[i]) merged[8*i +: 8] = wdata[8*i +: 8];
    end
    return merged;
  endfunction

endpackage

// File: rtl/mem_resp_latency_counter.sv
// Down-counter that times the access latency: load, decrement, registered zero flag.
module mem_resp_latency_counter
  import mem_bus_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  input  logic             dec_i,
  output logic             zero_o
);

  logic [CNT_W-1:0] count_q, count_d;
  logic             zero_q, zero_d;

  always_comb begin
    count_d = count_q;
    zero_d  = zero_q;
    if (load_i) begin
      count_d = load_val_i;
      zero_d  = (load_val_i == '0);
    end else if (dec_i && !zero_q) begin
      count_d = count_q - CNT_W'(1);
      zero_d  = (count_q == CNT_W'(1));
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
      zero_q  <= 1'b1;
    end else begin
      count_q <= count_d;
      zero_q  <= zero_d;
    end
  end

  assign zero_o = zero_q;

endmodule

// File: rtl/data_memory_responder.sv
// Handshaked multi-cycle word memory serving CPU data accesses one at a time,
// with byte-strobed stores and a live view of the array.
module data_memory_responder
  import mem_bus_pkg::*;
#(
  parameter int unsigned DEPTH   = 32,
  parameter int unsigned LATENCY = 2
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         req_valid,
  output logic                         req_ready,
  input  logic [ADDR_W-1:0]            req_addr,
  input  logic                         req_write,
  input  logic [WORD_W-1:0]            req_wdata,
  input  logic [WORD_BYTES-1:0]        req_wstrb,
  output logic                         resp_valid,
  input  logic                         resp_ready,
  output logic [WORD_W-1:0]            resp_rdata,
  output logic                         resp_err,
  input  logic [DEPTH-1:0][WORD_W-1:0] initial_values,
  output logic [DEPTH-1:0][WORD_W-1:0] memory_check
);

  localparam int unsigned IDX_W         = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam bit          SINGLE_CYCLE  = (LATENCY == 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'((LATENCY > 1) ? LATENCY - 2 : 0);

  resp_state_t state_q, state_d;

  logic [ADDR_W-1:0]     addr_q;
  logic                  write_q;
  logic [WORD_W-1:0]     wdata_q;
  logic [WORD_BYTES-1:0] wstrb_q;

  logic [DEPTH-1:0][WORD_W-1:0] mem_q;

  logic                  req_ready_q, req_ready_d;
  logic                  resp_valid_q, resp_valid_d;
  logic [WORD_W-1:0]     resp_rdata_q, resp_rdata_d;
  logic                  resp_err_q, resp_err_d;

  logic                  accept_c;
  logic                  commit_c;
  logic                  cnt_load_c;
  logic                  cnt_dec_c;
  logic                  cnt_zero_c;

  logic [ADDR_W-1:0]     acc_addr_c;
  logic                  acc_write_c;
  logic [WORD_W-1:0]     acc_wdata_c;
  logic [WORD_BYTES-1:0] acc_wstrb_c;
  logic                  acc_err_c;
  logic [IDX_W-1:0]      acc_idx_c;

  mem_resp_latency_counter u_lat_cnt (
    .clk        (clk),
    .reset      (reset),
    .load_i     (cnt_load_c),
    .load_val_i (CNT_LOAD),
    .dec_i      (cnt_dec_c),
    .zero_o     (cnt_zero_c)
  );

  // A single-cycle build commits on the accept edge, before the capture registers load.
  always_comb begin
    if (state_q == IDLE) begin
      acc_addr_c  = req_addr;
      acc_write_c = req_write;
      acc_wdata_c = req_wdata;
      acc_wstrb_c = req_wstrb;
    end else begin
      acc_addr_c  = addr_q;
      acc_write_c = write_q;
      acc_wdata_c = wdata_q;
      acc_wstrb_c = wstrb_q;
    end
  end

  assign acc_err_c = (acc_addr_c[1:0] != 2'b00) ||
                     (acc_addr_c[ADDR_W-1:2] >= (ADDR_W-2)'(DEPTH));
  assign acc_idx_c = IDX_W'(acc_addr_c[ADDR_W-1:2]);
  assign accept_c  = (state_q == IDLE) && req_valid;

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state and sequencing controls
  always_comb begin
    state_d    = state_q;
    commit_c   = 1'b0;
    cnt_load_c = 1'b0;
    cnt_dec_c  = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          if (SINGLE_CYCLE) begin
            commit_c = 1'b1;
            state_d  = RESP;
          end else begin
            cnt_load_c = 1'b1;
            state_d    = WAIT;
          end
        end
      end
      WAIT: begin
        if (cnt_zero_c) begin
          commit_c = 1'b1;
          state_d  = RESP;
        end else begin
          cnt_dec_c = 1'b1;
        end
      end
      RESP: begin
        if (resp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Output next values; response fields hold until the handshake clears them
  always_comb begin
    req_ready_d  = (state_d == IDLE);
    resp_valid_d = (state_d == RESP);
    resp_rdata_d = resp_rdata_q;
    resp_err_d   = resp_err_q;
    if (commit_c) begin
      resp_err_d   = acc_err_c;
      resp_rdata_d = (acc_err_c || acc_write_c) ? '0 : mem_q[acc_idx_c];
    end else if ((state_q == RESP) && resp_ready) begin
      resp_err_d   = 1'b0;
      resp_rdata_d = '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= '0;
      resp_err_q   <= 1'b0;
    end else begin
      req_ready_q  <= req_ready_d;
      resp_valid_q <= resp_valid_d;
      resp_rdata_q <= resp_rdata_d;
      resp_err_q   <= resp_err_d;
    end
  end

  // Request capture so later changes on req_* cannot disturb the access
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      addr_q  <= '0;
      write_q <= 1'b0;
      wdata_q <= '0;
      wstrb_q <= '0;
    end else if (accept_c) begin
      addr_q  <= req_addr;
      write_q <= req_write;
      wdata_q <= req_wdata;
      wstrb_q <= req_wstrb;
    end
  end

  // Word array, reloaded from initial_values whenever reset is held
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_q <= initial_values;
    end else if (commit_c && acc_write_c && !acc_err_c) begin
      mem_q[acc_idx_c] <= byte_merge(mem_q[acc_idx_c], acc_wdata_c, acc_wstrb_c);
    end
  end

  assign req_ready    = req_ready_q;
  assign resp_valid   = resp_valid_q;
  assign resp_rdata   = resp_rdata_q;
  assign resp_err     = resp_err_q;
  assign memory_check = mem_q;

endmodule

// File: tb/tb_data_memory_responder.sv
// Bench for data_memory_responder: three builds (LATENCY 2, 1, 4) checked against
// an array-based reference model, directed vectors and multi-cycle corner sequences.
module tb_data_memory_responder;

  localparam int unsigned DEPTH = 32;
  localparam int NI = 3;

  logic clk;
  logic rst        [NI];
  logic req_valid  [NI];
  logic req_ready  [NI];
  logic [31:0] req_addr  [NI];
  logic req_write  [NI];
  logic [31:0] req_wdata [NI];
  logic [3:0]  req_wstrb [NI];
  logic resp_valid [NI];
  logic resp_ready [NI];
  logic [31:0] resp_rdata [NI];
  logic resp_err   [NI];
  logic [DEPTH-1:0][31:0] init_vals;
  logic [DEPTH-1:0][31:0] mem_chk [NI];

  logic [31:0] mdl [NI][DEPTH];

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [31:0] addr;
    logic        wr;
    logic [31:0] wd;
    logic [3:0]  ws;
    int          hold;
    logic [31:0] exp_rd;
    logic        exp_err;
  } vec_t;

  vec_t tbl[9];

  function automatic int lat_of(input int d);
    return (d == 0) ? 2 : ((d == 1) ? 1 : 4);
  endfunction

  for (genvar g = 0; g < NI; g++) begin : g_dut
    data_memory_responder #(
      .DEPTH   (DEPTH),
      .LATENCY ((g == 0) ? 2 : ((g == 1) ? 1 : 4))
    ) u_dut (
      .clk            (clk),
      .reset          (rst[g]),
      .req_valid      (req_valid[g]),
      .req_ready      (req_ready[g]),
      .req_addr       (req_addr[g]),
      .req_write      (req_write[g]),
      .req_wdata      (req_wdata[g]),
      .req_wstrb      (req_wstrb[g]),
      .resp_valid     (resp_valid[g]),
      .resp_ready     (resp_ready[g]),
      .resp_rdata     (resp_rdata[g]),
      .resp_err       (resp_err[g]),
      .initial_values (init_vals),
      .memory_check   (mem_chk[g])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset(input int d);
    for (int i = 0; i < int'(DEPTH); i++) mdl[d][i] = init_vals[i];
  endtask

  // Reference: word memory with strictly serialised accesses
  task automatic model_access(input int d, input logic [31:0] addr, input logic wr,
                              input logic [31:0] wd, input logic [3:0] ws,
                              output logic [31:0] rd, output logic er);
    longint unsigned idx;
    idx = longint'(addr) / 4;
    er  = (addr % 4 != 0) || (idx >= DEPTH);
    rd  = 32'h0;
    if (!er) begin
      if (!wr) rd = mdl[d][idx];
      else for (int b = 0; b < 4; b++) if (ws[b]) mdl[d][idx][8*b +: 8] = wd[8*b +: 8];
    end
  endtask

  task automatic chk_mem(input int d);
    int bad;
    bad = 0;
    for (int i = DEPTH - 1; i >= 0; i--) if (mem_chk[d][i] !== mdl[d][i]) bad = i;
    chk($sformatf("memory_check[%0d] dut%0d", bad, d), mem_chk[d][bad], mdl[d][bad]);
  endtask

  // One full transaction; starts and ends at a negedge with the DUT idle
  task automatic do_txn(input int d, input logic [31:0] addr, input logic wr,
                        input logic [31:0] wd, input logic [3:0] ws, input int hold,
                        output logic [31:0] rd, output logic er);
    logic [31:0] e_rd;
    logic        e_er;
    int          n;
    bit          seen;
    model_access(d, addr, wr, wd, ws, e_rd, e_er);
    chk("req_ready_idle", 32'(req_ready[d]), 32'd1);
    req_valid[d] = 1'b1; req_addr[d] = addr; req_write[d] = wr;
    req_wdata[d] = wd;   req_wstrb[d] = ws;  resp_ready[d] = 1'b0;
    @(posedge clk);
    #1;
    req_valid[d] = 1'b0;
    req_addr[d]  = $urandom; req_wdata[d] = $urandom;
    req_wstrb[d] = 4'($urandom); req_write[d] = 1'($urandom);
    n = 1; seen = 0;
    while (!seen && n <= 40) begin
      @(negedge clk);
      if (resp_valid[d]) seen = 1;
      else begin
        if (req_ready[d]) chk("req_ready_busy", 32'(req_ready[d]), 32'd0);
        @(posedge clk);
        n++;
      end
    end
    if (!seen) begin
      chk("resp_timeout", 32'(resp_valid[d]), 32'd1);
      rd = 32'h0; er = 1'b0;
      return;
    end
    chk($sformatf("latency dut%0d", d), 32'(n), 32'(lat_of(d)));
    rd = resp_rdata[d]; er = resp_err[d];
    chk("resp_rdata", rd, e_rd);
    chk("resp_err", 32'(er), 32'(e_er));
    for (int h = 0; h < hold; h++) begin
      req_valid[d] = 1'b1;
      @(posedge clk); @(negedge clk);
      chk("hold_valid", 32'(resp_valid[d]), 32'd1);
      chk("hold_rdata", resp_rdata[d], rd);
      chk("hold_err", 32'(resp_err[d]), 32'(er));
      chk("hold_req_ready", 32'(req_ready[d]), 32'd0);
    end
    resp_ready[d] = 1'b1;
    @(posedge clk); @(negedge clk);
    resp_ready[d] = 1'b0; req_valid[d] = 1'b0;
    chk("post_hs_valid", 32'(resp_valid[d]), 32'd0);
    chk("post_hs_rdata", resp_rdata[d], 32'h0);
    chk("post_hs_err", 32'(resp_err[d]), 32'd0);
    chk("post_hs_ready", 32'(req_ready[d]), 32'd1);
    chk_mem(d);
  endtask

  // Held request and resp_ready: ready windows must recur every LATENCY+1 edges
  task automatic b2b(input int d);
    int edge_n, last, cnt;
    edge_n = 0; last = -1; cnt = 0;
    req_valid[d] = 1'b1; req_addr[d] = 32'h14; req_write[d] = 1'b0;
    req_wdata[d] = 32'h0; req_wstrb[d] = 4'h0; resp_ready[d] = 1'b1;
    while (cnt < 4 && edge_n < 60) begin
      if (resp_valid[d]) chk("b2b_rdata", resp_rdata[d], mdl[d][5]);
      if (req_ready[d]) begin
        if (last >= 0) chk($sformatf("b2b_period dut%0d", d), 32'(edge_n - last), 32'(lat_of(d) + 1));
        last = edge_n;
        cnt++;
        if (cnt == 4) req_valid[d] = 1'b0;
      end
      @(posedge clk); @(negedge clk);
      edge_n++;
    end
    if (cnt < 4) chk("b2b_timeout", 32'(cnt), 32'd4);
    req_valid[d] = 1'b0; resp_ready[d] = 1'b0;
    @(posedge clk); @(negedge clk);
  endtask

  initial begin
    logic [31:0] rd, a;
    logic        er;
    int          r;
    bit          quiet;

    for (int i = 0; i < int'(DEPTH); i++) init_vals[i] = 32'h1000_0000 + 32'(i) * 32'h0001_0101;
    init_vals[2] = 32'hAABBCCDD;
    init_vals[5] = 32'hDEADBEEF;
    for (int d = 0; d < NI; d++) begin
      rst[d] = 1'b1; req_valid[d] = 1'b0; req_addr[d] = 32'h0; req_write[d] = 1'b0;
      req_wdata[d] = 32'h0; req_wstrb[d] = 4'h0; resp_ready[d] = 1'b0;
      model_reset(d);
    end

    tbl[0] = '{32'h14, 1'b0, 32'h0,        4'hF, 0, 32'hDEADBEEF, 1'b0};
    tbl[1] = '{32'h08, 1'b1, 32'h11223344, 4'h5, 0, 32'h0,        1'b0};
    tbl[2] = '{32'h08, 1'b0, 32'h0,        4'h0, 0, 32'hAA22CC44, 1'b0};
    tbl[3] = '{32'h06, 1'b0, 32'h0,        4'hF, 0, 32'h0,        1'b1};
    tbl[4] = '{32'h80, 1'b0, 32'h0,        4'hF, 0, 32'h0,        1'b1};
    tbl[5] = '{32'h80, 1'b1, 32'hFFFFFFFF, 4'hF, 0, 32'h0,        1'b1};
    tbl[6] = '{32'h08, 1'b1, 32'h99999999, 4'h0, 0, 32'h0,        1'b0};
    tbl[7] = '{32'h08, 1'b0, 32'h0,        4'hF, 0, 32'hAA22CC44, 1'b0};
    tbl[8] = '{32'h14, 1'b0, 32'h0,        4'h0, 5, 32'hDEADBEEF, 1'b0};

    repeat (3) @(negedge clk);
    for (int d = 0; d < NI; d++) rst[d] = 1'b0;
    @(negedge clk);

    for (int d = 0; d < NI; d++) begin
      chk("rst_req_ready", 32'(req_ready[d]), 32'd1);
      chk("rst_resp_valid", 32'(resp_valid[d]), 32'd0);
      chk("rst_resp_rdata", resp_rdata[d], 32'h0);
      chk("rst_resp_err", 32'(resp_err[d]), 32'd0);
      chk_mem(d);
    end

    for (int v = 0; v < 9; v++) begin
      do_txn(0, tbl[v].addr, tbl[v].wr, tbl[v].wd, tbl[v].ws, tbl[v].hold, rd, er);
      chk($sformatf("vec%0d_rdata", v), rd, tbl[v].exp_rd);
      chk($sformatf("vec%0d_err", v), 32'(er), 32'(tbl[v].exp_err));
    end
    chk("vec_mem2", mem_chk[0][2], 32'hAA22CC44);

    // Async reset while a store waits in the LATENCY=4 build
    do_txn(2, 32'h0, 1'b1, 32'hCAFEF00D, 4'hF, 0, rd, er);
    chk("pre_rst_mem0", mem_chk[2][0], 32'hCAFEF00D);
    req_valid[2] = 1'b1; req_addr[2] = 32'h0; req_write[2] = 1'b1;
    req_wdata[2] = 32'h0BADC0DE; req_wstrb[2] = 4'hF;
    @(posedge clk);
    #2 req_valid[2] = 1'b0;
    @(negedge clk);
    #1 rst[2] = 1'b1;
    #1;
    chk("arst_req_ready", 32'(req_ready[2]), 32'd1);
    chk("arst_resp_valid", 32'(resp_valid[2]), 32'd0);
    chk("arst_mem0", mem_chk[2][0], init_vals[0]);
    @(negedge clk);
    rst[2] = 1'b0;
    model_reset(2);
    quiet = 1;
    repeat (8) begin
      @(negedge clk);
      if (resp_valid[2]) quiet = 0;
    end
    chk("arst_no_resp", 32'(quiet), 32'd1);
    chk_mem(2);

    for (int d = 0; d < NI; d++) b2b(d);

    for (int d = 0; d < NI; d++) begin
      for (int t = 0; t < 30; t++) begin
        r = $urandom_range(0, 9);
        if (r < 7)       a = 32'($urandom_range(0, DEPTH - 1)) << 2;
        else if (r == 7) a = (32'($urandom_range(0, DEPTH - 1)) << 2) | 32'($urandom_range(1, 3));
        else if (r == 8) a = (32'(DEPTH) + 32'($urandom_range(0, 100))) << 2;
        else             a = $urandom;
        do_txn(d, a, 1'($urandom), $urandom, 4'($urandom), $urandom_range(0, 3), rd, er);
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
